// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared defaults and state encoding for the acquisition window generator
package acq_pkg;

    localparam int DEF_DATA_W  = 10;
    localparam int DEF_DLY_W   = 16;
    localparam int DEF_LEN_W   = 14;
    localparam int DEF_FCNT_W  = 16;
    localparam int DEF_GAP_CYC = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ACQ   = 2'd2,
        GAP   = 2'd3
    } acq_state_e;

endpackage

// File: rtl/acq_window_trig_sync.sv
// rtl/acq_window_trig_sync.sv - two-flop trigger synchroniser with rising-edge detect
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   trig_in   asynchronous pulser trigger
//   trig_rise one-cycle pulse on the first synchronised high sample
module trig_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic trig_in,
    output logic trig_rise
);

    logic sync1_q;
    logic sync2_q;
    logic edge_q;

    // All stages reset high so a trigger held high through reset release
    // never looks like a fresh edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            edge_q  <= 1'b1;
        end else begin
            sync1_q <= trig_in;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign trig_rise = sync2_q & ~edge_q;

endmodule

// File: rtl/acq_window.sv
// rtl/acq_window.sv - trigger-synchronised acquisition window generator feeding the frame averager
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   trig_in          asynchronous pulser trigger, rising-edge active
//   acq_enable       gates acceptance of new triggers
//   adc_data         ADC sample stream
//   delay_cfg        trigger-to-window delay (cycles), sampled on accepted trigger
//   length_cfg       window length (samples), sampled on accepted trigger
//   data_out         registered sample (1-cycle latency)
//   data_out_valid   window level, aligned to data_out
//   busy             high while a frame (delay, window or gap) is in progress
//   trig_miss        one-cycle pulse per rejected trigger edge
//   frame_cnt        completed windows, wrapping
//
// Build option: ACQ_TEST_PATTERN_EN replaces adc_data with a per-frame ramp.
module acq_window
    import acq_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DLY_W   = DEF_DLY_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int FCNT_W  = DEF_FCNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trig_in,
    input  logic              acq_enable,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DLY_W-1:0]  delay_cfg,
    input  logic [LEN_W-1:0]  length_cfg,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              busy,
    output logic              trig_miss,
    output logic [FCNT_W-1:0] frame_cnt
);

    // The gap is counted in the delay counter, which is idle during GAP.
    localparam logic [DLY_W-1:0] GAP_LAST = DLY_W'(GAP_CYC - 1);

    logic              trig_rise;
    acq_state_e        state_q, state_d;
    logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
    logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [DATA_W-1:0] data_out_q, data_d;
    logic              valid_q, busy_q, miss_q;
    logic              accept, frame_done;

    trig_sync u_trig_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .trig_in   (trig_in),
        .trig_rise (trig_rise)
    );

    always_comb begin
        state_d    = state_q;
        dly_cnt_d  = dly_cnt_q;
        len_cnt_d  = len_cnt_q;
        accept     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_rise && acq_enable && (length_cfg != '0)) begin
                    accept    = 1'b1;
                    len_cnt_d = length_cfg - 1'b1;
                    if (delay_cfg == '0) begin
                        state_d = ACQ;
                    end else begin
                        state_d   = DELAY;
                        dly_cnt_d = delay_cfg - 1'b1;
                    end
                end
            end
            DELAY: begin
                if (dly_cnt_q == '0) state_d = ACQ;
                else                 dly_cnt_d = dly_cnt_q - 1'b1;
            end
            ACQ: begin
                if (len_cnt_q == '0) begin
                    state_d    = GAP;
                    frame_done = 1'b1;
                    dly_cnt_d  = GAP_LAST;
                end else begin
                    len_cnt_d = len_cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (dly_cnt_q == '0) state_d = IDLE;
                else                 dly_cnt_d = dly_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ACQ_TEST_PATTERN_EN
    // Ramp restarts at 0 on acceptance; it advances on every edge that lands
    // in ACQ so the value registered on that edge is the sample index.
    logic [DATA_W-1:0] ramp_q, ramp_base;

    assign ramp_base = accept ? '0 : ramp_q;
    assign data_d    = ramp_base;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ramp_q <= '0;
        else          ramp_q <= (state_d == ACQ) ? ramp_base + 1'b1 : ramp_base;
    end
`else
    assign data_d = adc_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dly_cnt_q   <= '0;
            len_cnt_q   <= '0;
            frame_cnt_q <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_cnt_q  <= dly_cnt_d;
            len_cnt_q  <= len_cnt_d;
            data_out_q <= data_d;
            // Valid and busy follow the next state so they line up with data_out.
            valid_q    <= (state_d == ACQ);
            busy_q     <= (state_d != IDLE);
            miss_q     <= trig_rise & ~accept;
            if (frame_done) frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign busy           = busy_q;
    assign trig_miss      = miss_q;
    assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_acq_window.sv
// tb/tb_acq_window.sv - randomized self-checking bench for acq_window
module tb_acq_window;
    import acq_pkg::*;

`ifdef ACQ_TEST_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic trig_in = 1'b0;
    logic acq_enable = 1'b0;
    logic [DEF_DATA_W-1:0] adc_data = '0;
    logic [DEF_DLY_W-1:0]  delay_cfg = '0;
    logic [DEF_LEN_W-1:0]  length_cfg = '0;
    logic [DEF_DATA_W-1:0] data_out;
    logic data_out_valid, busy, trig_miss;
    logic [DEF_FCNT_W-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    acq_window dut (
        .clk(clk), .reset_n(reset_n), .trig_in(trig_in), .acq_enable(acq_enable),
        .adc_data(adc_data), .delay_cfg(delay_cfg), .length_cfg(length_cfg),
        .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy),
        .trig_miss(trig_miss), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model in edge numbers: a trigger sampled high (after a low
    // sample) at edge k is decided at edge k+2; an accepted one opens a window
    // over edges [k+2+delay, k+1+delay+len] and frees the engine gap cycles later.
    longint n, acc_e, win_s, win_e, free_at;
    bit p1, p2, p3;
    logic m_valid, m_busy, m_miss;
    logic [DEF_FCNT_W-1:0] m_frames;
    logic [DEF_DATA_W-1:0] m_data;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n = 0; acc_e = 0; free_at = 0; win_s = 1; win_e = 0;
            p1 = 1; p2 = 1; p3 = 1;
            m_valid = 0; m_busy = 0; m_miss = 0; m_frames = '0; m_data = '0;
        end else begin
            n = n + 1;
            if (n == win_e + 1 && win_e >= win_s) m_frames = m_frames + 1'b1;
            m_miss = 1'b0;
            if (p2 && !p3) begin
                if (n - 1 >= free_at && acq_enable && length_cfg != '0) begin
                    acc_e   = n;
                    win_s   = n + longint'(delay_cfg);
                    win_e   = win_s + longint'(length_cfg) - 1;
                    free_at = win_e + 1 + DEF_GAP_CYC;
                end else begin
                    m_miss = 1'b1;
                end
            end
            p3 = p2; p2 = p1; p1 = trig_in;
            m_valid = (n >= win_s) && (n <= win_e);
            m_busy  = (n >= acc_e) && (n < free_at);
            if (PAT) m_data = DEF_DATA_W'(n - win_s);
            else     m_data = adc_data;
        end
    end

    task automatic step();
        @(negedge clk);
        adc_data = DEF_DATA_W'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; trig_in = 1'b0;
        repeat (3) step();
        checks++;
        if ({data_out, data_out_valid, busy, trig_miss, frame_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_values got d=%0d v=%b b=%b m=%b f=%0d want all 0", data_out, data_out_valid, busy, trig_miss, frame_cnt);
        end
        reset_n = 1'b1;
        repeat (4) begin
            step();
            checks++;
            if ({data_out_valid, busy, trig_miss, frame_cnt} !== {m_valid, m_busy, m_miss, m_frames}) begin
                errors++;
                $display("FAIL reset_idle got v/b/m/f=%b/%b/%b/%0d want %b/%b/%b/%0d", data_out_valid, busy, trig_miss, frame_cnt, m_valid, m_busy, m_miss, m_frames);
            end
        end
    endtask

    task automatic test_single();
        int first = -1;
        int highs = 0;
        delay_cfg = 16'd5; length_cfg = 14'd8; acq_enable = 1'b1;
        trig_in = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            step();
            if (j == 3) trig_in = 1'b0;
            if (data_out_valid === 1'b1 && first < 0) first = j;
            if (data_out_valid === 1'b1) highs++;
            checks++;
            if ({data_out_valid, busy, trig_miss, frame_cnt} !== {m_valid, m_busy, m_miss, m_frames}) begin
                errors++;
                $display("FAIL single_ctl n=%0d got v/b/m/f=%b/%b/%b/%0d want %b/%b/%b/%0d", n, data_out_valid, busy, trig_miss, frame_cnt, m_valid, m_busy, m_miss, m_frames);
            end
            if (!PAT || m_valid) begin
                checks++;
                if (data_out !== m_data) begin
                    errors++;
                    $display("FAIL single_data n=%0d got %0d want %0d", n, data_out, m_data);
                end
            end
        end
        checks++;
        if (first != 8) begin errors++; $display("FAIL single_rise got step %0d want 8", first); end
        checks++;
        if (highs != 8) begin errors++; $display("FAIL single_len got %0d want 8", highs); end
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frames got %0d want 1", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int nxt = 0, first = -1, run_hi = 0, max_hi = 0, run_lo = 0, min_lo = 1000;
        bit seen = 0;
        delay_cfg = '0; length_cfg = 14'd1; acq_enable = 1'b1;
        for (int j = 0; j < 150; j++) begin
            trig_in = (j == nxt);
            if (j == nxt) nxt = j + 2 + int'($urandom_range(0, 7));
            step();
            if (data_out_valid === 1'b1) begin
                if (first < 0) first = j;
                if (seen && run_lo < min_lo) min_lo = run_lo;
                run_lo = 0; run_hi++; seen = 1;
            end else begin
                if (run_hi > max_hi) max_hi = run_hi;
                run_hi = 0;
                if (seen) run_lo++;
            end
            checks++;
            if ({data_out_valid, busy, trig_miss, frame_cnt} !== {m_valid, m_busy, m_miss, m_frames}) begin
                errors++;
                $display("FAIL b2b_ctl n=%0d got v/b/m/f=%b/%b/%b/%0d want %b/%b/%b/%0d", n, data_out_valid, busy, trig_miss, frame_cnt, m_valid, m_busy, m_miss, m_frames);
            end
        end
        trig_in = 1'b0;
        repeat (8) step();
        checks++;
        if (first != 2) begin errors++; $display("FAIL b2b_first got %0d want 2", first); end
        checks++;
        if (max_hi != 1) begin errors++; $display("FAIL b2b_width got %0d want 1", max_hi); end
        checks++;
        if (min_lo < DEF_GAP_CYC) begin errors++; $display("FAIL b2b_gap got %0d want >=%0d", min_lo, DEF_GAP_CYC); end
    endtask

    task automatic test_retrigger();
        int d = int'($urandom_range(3, 10));
        int l = int'($urandom_range(6, 20));
        int misses = 0, highs = 0;
        logic [DEF_FCNT_W-1:0] f_exp = m_frames + 1'b1;
        delay_cfg = DEF_DLY_W'(d); length_cfg = DEF_LEN_W'(l); acq_enable = 1'b1;
        trig_in = 1'b1;
        for (int j = 1; j <= d + l + 14; j++) begin
            step();
            trig_in = (j < 2) || (j == d + 3);
            misses += int'(trig_miss === 1'b1);
            highs  += int'(data_out_valid === 1'b1);
            checks++;
            if ({data_out_valid, busy, trig_miss, frame_cnt} !== {m_valid, m_busy, m_miss, m_frames}) begin
                errors++;
                $display("FAIL retrig_ctl n=%0d got v/b/m/f=%b/%b/%b/%0d want %b/%b/%b/%0d", n, data_out_valid, busy, trig_miss, frame_cnt, m_valid, m_busy, m_miss, m_frames);
            end
        end
        checks++;
        if (misses != 1) begin errors++; $display("FAIL retrig_miss got %0d want 1", misses); end
        checks++;
        if (highs != l) begin errors++; $display("FAIL retrig_len got %0d want %0d", highs, l); end
        checks++;
        if (frame_cnt !== f_exp) begin errors++; $display("FAIL retrig_frames got %0d want %0d", frame_cnt, f_exp); end
    endtask

    task automatic test_reject();
        for (int sc = 0; sc < 2; sc++) begin
            int misses = 0, highs = 0, busys = 0;
            delay_cfg = 16'd2;
            length_cfg = (sc == 0) ? 14'd0 : 14'd5;
            acq_enable = (sc != 0) ? 1'b0 : 1'b1;
            trig_in = 1'b1;
            for (int j = 1; j <= 12; j++) begin
                step();
                if (j == 3) trig_in = 1'b0;
                misses += int'(trig_miss === 1'b1);
                highs  += int'(data_out_valid === 1'b1);
                busys  += int'(busy === 1'b1);
            end
            checks++;
            if (misses != 1 || highs != 0 || busys != 0) begin
                errors++;
                $display("FAIL reject_%0d got miss=%0d valid=%0d busy=%0d want 1/0/0", sc, misses, highs, busys);
            end
        end
        acq_enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        delay_cfg = 16'd2; length_cfg = 14'd40; acq_enable = 1'b1;
        trig_in = 1'b1;
        while (data_out_valid !== 1'b1 && guard < 20) begin
            step(); guard++;
            if (guard == 2) trig_in = 1'b0;
        end
        checks++;
        if (data_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_start got valid=%b want 1 within 20 cycles", data_out_valid); end
        step();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({data_out, data_out_valid, busy, trig_miss, frame_cnt} !== '0) begin
            errors++;
            $display("FAIL rstmid_async got d=%0d v=%b b=%b m=%b f=%0d want all 0", data_out, data_out_valid, busy, trig_miss, frame_cnt);
        end
        trig_in = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step();
            checks++;
            if ({data_out_valid, busy, trig_miss, frame_cnt} !== 19'd0) begin
                errors++;
                $display("FAIL rstmid_held got v/b/m/f=%b/%b/%b/%0d want 0/0/0/0", data_out_valid, busy, trig_miss, frame_cnt);
            end
        end
        trig_in = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_random();
        for (int j = 0; j < 800; j++) begin
            if ($urandom_range(0, 15) == 0) delay_cfg = DEF_DLY_W'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) length_cfg = DEF_LEN_W'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) acq_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) trig_in = ~trig_in;
            step();
            checks++;
            if ({data_out_valid, busy, trig_miss, frame_cnt} !== {m_valid, m_busy, m_miss, m_frames}) begin
                errors++;
                $display("FAIL random_ctl n=%0d got v/b/m/f=%b/%b/%b/%0d want %b/%b/%b/%0d", n, data_out_valid, busy, trig_miss, frame_cnt, m_valid, m_busy, m_miss, m_frames);
            end
            if (!PAT || m_valid) begin
                checks++;
                if (data_out !== m_data) begin
                    errors++;
                    $display("FAIL random_data n=%0d got %0d want %0d", n, data_out, m_data);
                end
            end
        end
        trig_in = 1'b0; acq_enable = 1'b1;
        repeat (30) step();
    endtask

`ifdef ACQ_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [DEF_DATA_W-1:0] last = '0;
        logic was_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        delay_cfg = 16'd3; length_cfg = 14'd1030; acq_enable = 1'b1;
        for (int j = 0; j < 32 * 1045; j++) begin
            trig_in = ((j % 1045) == 0);
            step();
            if (m_valid) begin
                checks++;
                if (data_out !== m_data) begin
                    errors++;
                    $display("FAIL pattern_data n=%0d got %0d want %0d", n, data_out, m_data);
                end
            end
            if (was_valid && data_out_valid !== 1'b1) begin
                checks++;
                if (last !== 10'd5) begin errors++; $display("FAIL pattern_last got %0d want 5", last); end
            end
            was_valid = (data_out_valid === 1'b1);
            last = data_out;
        end
        checks++;
        if (frame_cnt !== 16'd32) begin errors++; $display("FAIL pattern_frames got %0d want 32", frame_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_retrigger();
        test_reject();
        test_reset_mid();
        test_random();
`ifdef ACQ_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
